gray_counter_ud: RTL and testbench

Parametrised up/down Gray-code counter for clock-domain-crossing pointers and position encoders. It keeps a binary count and a matching Gray code, both registered, and supports enable, direction, synchronous load/clear, and a choice of wrap or saturate at the range limits. It also produces a zero flag, a wrap pulse and a blocked-step pulse. It is the general replacement for the fixed-width, up-only Gray counters in the benchmark set and sits directly behind FIFO pointer logic or any block needing single-bit-change sequences.

---
 rtl/gray_counter_ud.sv | 74 +++++++
 tb/tb_gray_counter_ud.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gray_counter_ud.sv
// Up/down Gray-code counter with registered binary and Gray outputs.
// Supports clear, load, wrap-or-saturate at the range limits, and wrap/blocked-step pulses.
module gray_counter_ud #(
  parameter int          CBITS    = 14,
  parameter int          SAT_MODE = 0,
  parameter int unsigned INIT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [CBITS-1:0] load_val,
  output logic [CBITS-1:0] bin_c,
  output logic [CBITS-1:0] gray_c,
  output logic             zero,
  output logic             wrap,
  output logic             blk
);

  localparam logic [CBITS-1:0] INIT_V = CBITS'(INIT);
  localparam logic [CBITS-1:0] MAX_V  = '1;
  localparam logic [CBITS-1:0] ONE_V  = CBITS'(1);

  logic [CBITS-1:0] bin_q, bin_d;
  logic [CBITS-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             blk_q, blk_d;
  logic             atLimit;

  assign atLimit = up ? (bin_q == MAX_V) : (bin_q == '0);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    blk_d  = 1'b0;
    if (clr) begin
      bin_d = INIT_V;
    end else if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (atLimit && (SAT_MODE != 0)) begin
        blk_d = 1'b1;
      end else begin
        // Modulo arithmetic yields the wrapped value at either limit for free
        bin_d  = up ? (bin_q + ONE_V) : (bin_q - ONE_V);
        wrap_d = atLimit;
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= INIT_V;
      gray_q <= INIT_V ^ (INIT_V >> 1);
      wrap_q <= 1'b0;
      blk_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      blk_q  <= blk_d;
    end
  end

  assign bin_c  = bin_q;
  assign gray_c = gray_q;
  assign zero   = (bin_q == '0);
  assign wrap   = wrap_q;
  assign blk    = blk_q;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Drives three 4-bit counters (wrap/INIT=0, saturate/INIT=0, wrap/INIT=5) with shared stimulus
// and compares every cycle against an integer-arithmetic reference model.
module tb_gray_counter_ud;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] binC [3];
  logic [3:0] grayC [3];
  logic       zeroC [3];
  logic       wrapC [3];
  logic       blkC [3];

  int nChecks = 0;
  int nFail = 0;

  // reference model state, one entry per DUT
  int satArr [3] = '{0, 1, 0};
  int initArr [3] = '{0, 0, 5};
  int mCnt [3];
  int mWrap [3];
  int mBlk [3];
  int mStep [3];
  int mPrevCnt [3];

  always #5 clk = ~clk;

  gray_counter_ud #(.CBITS(4), .SAT_MODE(0), .INIT(0)) dutWrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .bin_c(binC[0]), .gray_c(grayC[0]), .zero(zeroC[0]), .wrap(wrapC[0]), .blk(blkC[0]));

  gray_counter_ud #(.CBITS(4), .SAT_MODE(1), .INIT(0)) dutSat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .bin_c(binC[1]), .gray_c(grayC[1]), .zero(zeroC[1]), .wrap(wrapC[1]), .blk(blkC[1]));

  gray_counter_ud #(.CBITS(4), .SAT_MODE(0), .INIT(5)) dutInit (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .bin_c(binC[2]), .gray_c(grayC[2]), .zero(zeroC[2]), .wrap(wrapC[2]), .blk(blkC[2]));

  function automatic int grayOf(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bin[%0d]", k), int'(binC[k]), mCnt[k]);
      checkOutput($sformatf("gray[%0d]", k), int'(grayC[k]), grayOf(mCnt[k]));
      checkOutput($sformatf("zero[%0d]", k), int'(zeroC[k]), (mCnt[k] == 0) ? 1 : 0);
      checkOutput($sformatf("wrap[%0d]", k), int'(wrapC[k]), mWrap[k]);
      checkOutput($sformatf("blk[%0d]", k), int'(blkC[k]), mBlk[k]);
      if (mStep[k] != 0)
        checkOutput($sformatf("grayOneBit[%0d]", k),
                    $countones(int'(grayC[k]) ^ grayOf(mPrevCnt[k])), 1);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic clrV, input logic loadV,
                               input logic enV, input logic upV, input int lv);
    int nxt;
    rst_n = rstN; clr = clrV; load = loadV; en = enV; up = upV; load_val = 4'(lv);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      mPrevCnt[k] = mCnt[k];
      mStep[k] = 0;
      mWrap[k] = 0;
      mBlk[k] = 0;
      if (!rstN || clrV) begin
        mCnt[k] = initArr[k];
      end else if (loadV) begin
        mCnt[k] = lv;
      end else if (enV) begin
        nxt = upV ? mCnt[k] + 1 : mCnt[k] - 1;
        if (nxt < 0 || nxt > 15) begin
          if (satArr[k] != 0) begin
            mBlk[k] = 1;
          end else begin
            mCnt[k] = (nxt + 16) % 16;
            mWrap[k] = 1;
            mStep[k] = 1;
          end
        end else begin
          mCnt[k] = nxt;
          mStep[k] = 1;
        end
      end
    end
    #1;
    checkAll();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mCnt[k] = 0; mWrap[k] = 0; mBlk[k] = 0; mStep[k] = 0; mPrevCnt[k] = 0;
    end
    @(negedge clk);

    // full up sweep through the wrap point
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);

    // single down step from zero
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // saturation at both ends
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 14);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // priority among clr, load and en
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6);

    // reset mid-count overrides everything
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // random traffic, loads biased toward the range limits
    for (int i = 0; i < 400; i++) begin
      int lv;
      lv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 15 : 0)
                                       : int'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) == 1), lv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
